health_bar_layer: RTL and testbench

- Generates one health-bar overlay layer for the display compositor (player or opponent instance).
- Converts hcount/vcount plus game health updates into a 24-bit RGB layer pixel.
- Value 0 means transparent; the compositor falls through to lower layers.
- Animates damage with a white flash followed by a gradual drain segment. Bar geometry is tear-free because drawn values update only at frame start.

---
 rtl/health_bar_layer.sv | 207 ++++++++++++++++++++
 tb/tb_health_bar_layer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/health_bar_layer.sv
// Health-bar overlay layer: turns hcount/vcount and health updates into a 24-bit layer pixel (0 = transparent).
// Optional HEALTH_BORDER_EN draws a one-pixel white outline around the bar.
module health_bar_layer #(
  parameter int          BAR_X        = 32,
  parameter int          BAR_Y        = 16,
  parameter int          BAR_H        = 16,
  parameter int          MAX_HEALTH   = 100,
  parameter int          PX_PER_HP    = 2,
  parameter int          FLASH_FRAMES = 8,
  parameter int          DRAIN_FRAMES = 2,
  parameter logic [23:0] COLOR_FILL   = 24'hFF0000,
  parameter logic [23:0] COLOR_DRAIN  = 24'hFFC000,
  parameter logic [23:0] COLOR_EMPTY  = 24'h404040
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        frame_start_in,
  input  logic [7:0]  health_in,
  input  logic        health_valid_in,
  output logic [23:0] pixel_out,
  output logic        flash_active_out,
  output logic        depleted_out
);

  localparam int          BAR_W       = MAX_HEALTH * PX_PER_HP;
  localparam logic [10:0] X_LO        = 11'(BAR_X);
  localparam logic [10:0] X_HI        = 11'(BAR_X + BAR_W);
  localparam logic [9:0]  Y_LO        = 10'(BAR_Y);
  localparam logic [9:0]  Y_HI        = 10'(BAR_Y + BAR_H);
  localparam logic [7:0]  MAX_H       = 8'(MAX_HEALTH);
  localparam logic [15:0] PX16        = 16'(PX_PER_HP);
  localparam logic [7:0]  FLASH_LAST  = 8'(FLASH_FRAMES - 1);
  localparam logic [7:0]  DRAIN_LAST  = 8'(DRAIN_FRAMES - 1);
  localparam logic [23:0] COLOR_WHITE = 24'hFFFFFF;
`ifdef HEALTH_BORDER_EN
  localparam logic [10:0] XOFF_LAST   = 11'(BAR_W - 1);
  localparam logic [9:0]  Y_LAST      = 10'(BAR_Y + BAR_H - 1);
`endif

  typedef enum logic [1:0] {IDLE, FLASH, DRAIN} state_t;

  function automatic logic [7:0] clamp_health(input logic [7:0] h);
    return (h > MAX_H) ? MAX_H : h;
  endfunction

  function automatic logic [15:0] hp_to_px(input logic [7:0] hp);
    return {8'd0, hp} * PX16;
  endfunction

  state_t      state, nxt_state;
  logic [7:0]  target, nxt_target;
  logic [7:0]  shown, nxt_shown;
  logic [7:0]  flash_cnt, nxt_flash_cnt;
  logic [7:0]  drain_cnt, nxt_drain_cnt;
  logic [7:0]  health_clamped;

  logic [7:0]  shadow_target;
  logic [7:0]  shadow_shown;
  logic        shadow_flash;

  assign health_clamped = clamp_health(health_in);

  // Health update is applied first; the frame tick then advances from the updated state.
  always_comb begin
    nxt_state     = state;
    nxt_target    = target;
    nxt_shown     = shown;
    nxt_flash_cnt = flash_cnt;
    nxt_drain_cnt = drain_cnt;

    if (health_valid_in) begin
      if (state == IDLE) begin
        if (health_clamped < shown) begin
          nxt_target    = health_clamped;
          nxt_flash_cnt = 8'd0;
          nxt_state     = FLASH;
        end else begin
          nxt_target = health_clamped;
          nxt_shown  = health_clamped;
        end
      end else begin
        if (health_clamped < target) begin
          nxt_target    = health_clamped;
          nxt_flash_cnt = 8'd0;
          nxt_state     = FLASH;
        end else if (health_clamped >= shown) begin
          nxt_target = health_clamped;
          nxt_shown  = health_clamped;
          nxt_state  = IDLE;
        end else begin
          nxt_target = health_clamped;
        end
      end
    end

    if (frame_start_in) begin
      case (nxt_state)
        FLASH: begin
          if (nxt_flash_cnt == FLASH_LAST) begin
            nxt_state     = DRAIN;
            nxt_drain_cnt = 8'd0;
          end else begin
            nxt_flash_cnt = nxt_flash_cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (nxt_drain_cnt == DRAIN_LAST) begin
            nxt_shown     = nxt_shown - 8'd1;
            nxt_drain_cnt = 8'd0;
            if (nxt_shown == nxt_target) nxt_state = IDLE;
          end else begin
            nxt_drain_cnt = nxt_drain_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= IDLE;
      target           <= MAX_H;
      shown            <= MAX_H;
      flash_cnt        <= 8'd0;
      drain_cnt        <= 8'd0;
      flash_active_out <= 1'b0;
      depleted_out     <= 1'b0;
    end else begin
      state            <= nxt_state;
      target           <= nxt_target;
      shown            <= nxt_shown;
      flash_cnt        <= nxt_flash_cnt;
      drain_cnt        <= nxt_drain_cnt;
      flash_active_out <= (nxt_state == FLASH);
      depleted_out     <= (nxt_target == 8'd0) && (nxt_shown == 8'd0);
    end
  end

  // Shadows capture the pre-update registers so a frame is drawn from one consistent snapshot.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      shadow_target <= MAX_H;
      shadow_shown  <= MAX_H;
      shadow_flash  <= 1'b0;
    end else if (frame_start_in) begin
      shadow_target <= target;
      shadow_shown  <= shown;
      shadow_flash  <= (state == FLASH);
    end
  end

  // ---- stage 1: bar hit test and horizontal offset ----
  logic        in_bar_p1;
  logic [10:0] x_off_p1;
`ifdef HEALTH_BORDER_EN
  logic        edge_row_p1;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      in_bar_p1 <= 1'b0;
    end else begin
      in_bar_p1 <= (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                   (vcount_in >= Y_LO) && (vcount_in < Y_HI);
    end
  end

  always_ff @(posedge clk_in) begin
    x_off_p1 <= hcount_in - X_LO;
`ifdef HEALTH_BORDER_EN
    edge_row_p1 <= (vcount_in == Y_LO) || (vcount_in == Y_LAST);
`endif
  end

  // ---- stage 2: colour select ----
  logic [15:0] fill_lim;
  logic [15:0] drain_lim;
  logic [23:0] colour_p1;

  assign fill_lim  = hp_to_px(shadow_target);
  assign drain_lim = hp_to_px(shadow_shown);

  always_comb begin
    colour_p1 = 24'd0;
    if (in_bar_p1) begin
      if ({5'd0, x_off_p1} < fill_lim)
        colour_p1 = shadow_flash ? COLOR_WHITE : COLOR_FILL;
      else if ({5'd0, x_off_p1} < drain_lim)
        colour_p1 = COLOR_DRAIN;
      else
        colour_p1 = COLOR_EMPTY;
`ifdef HEALTH_BORDER_EN
      if ((x_off_p1 == 11'd0) || (x_off_p1 == XOFF_LAST) || edge_row_p1)
        colour_p1 = COLOR_WHITE;
`endif
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) pixel_out <= 24'd0;
    else         pixel_out <= colour_p1;
  end

endmodule

// File: tb/tb_health_bar_layer.sv
// Self-checking bench for health_bar_layer: directed health scenarios with randomized pixel probes
// checked every cycle against a behavioural model of the bar.
module tb_health_bar_layer;

  localparam int BAR_X = 32, BAR_Y = 16, BAR_H = 16, MAXH = 100, PXHP = 2;
  localparam int BAR_W = MAXH * PXHP;
  localparam int FLASH_N = 8, DRAIN_N = 2;
  localparam int FRAME = 16;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        frame_start_in;
  logic [7:0]  health_in;
  logic        health_valid_in;
  logic [23:0] pixel_out;
  logic        flash_active_out;
  logic        depleted_out;

  health_bar_layer dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .frame_start_in  (frame_start_in),
    .health_in       (health_in),
    .health_valid_in (health_valid_in),
    .pixel_out       (pixel_out),
    .flash_active_out(flash_active_out),
    .depleted_out    (depleted_out)
  );

  always #5 clk_in = ~clk_in;

  int nvec = 0;
  int nerr = 0;

  // model: phase 0 = idle, 1 = flashing, 2 = draining
  int m_phase, m_target, m_shown, m_flash_frames, m_drain_frames;
  int sh_target, sh_shown;
  bit sh_flash;
  int px, py;
  bit pv;
  logic [23:0] exp_pix;

  int x_offs[20] = '{-1, 0, 1, 59, 60, 79, 80, 89, 90, 119, 120, 121, 159, 160, 179, 180, 198, 199, 200, 201};
  int y_vals[8]  = '{15, 16, 17, 24, 30, 31, 32, 20};

  task automatic model_reset();
    m_phase = 0; m_target = MAXH; m_shown = MAXH;
    m_flash_frames = 0; m_drain_frames = 0;
    sh_target = MAXH; sh_shown = MAXH; sh_flash = 0;
    pv = 0; exp_pix = 24'd0;
  endtask

  function automatic logic [23:0] colour(input int x, input int y);
    int off;
    if (x < BAR_X || x >= BAR_X + BAR_W || y < BAR_Y || y >= BAR_Y + BAR_H) return 24'd0;
    off = x - BAR_X;
`ifdef HEALTH_BORDER_EN
    if (off == 0 || off == BAR_W - 1 || y == BAR_Y || y == BAR_Y + BAR_H - 1) return 24'hFFFFFF;
`endif
    if (off < sh_target * PXHP) return sh_flash ? 24'hFFFFFF : 24'hFF0000;
    if (off < sh_shown * PXHP) return 24'hFFC000;
    return 24'h404040;
  endfunction

  task automatic model_edge();
    int h, old_t, old_s;
    bit old_f;
    if (!rst_in) begin
      exp_pix = 24'd0;
      pv = 0;
      return;
    end
    exp_pix = pv ? colour(px, py) : 24'd0;
    pv = 1; px = int'(hcount_in); py = int'(vcount_in);
    old_t = m_target; old_s = m_shown; old_f = (m_phase == 1);
    if (health_valid_in) begin
      h = (int'(health_in) > MAXH) ? MAXH : int'(health_in);
      if (h < m_target) begin
        m_target = h; m_flash_frames = 0; m_phase = 1;
      end else if (h >= m_shown) begin
        m_target = h; m_shown = h; m_phase = 0;
      end else begin
        m_target = h;
      end
    end
    if (frame_start_in) begin
      sh_target = old_t; sh_shown = old_s; sh_flash = old_f;
      if (m_phase == 1) begin
        m_flash_frames++;
        if (m_flash_frames == FLASH_N) begin
          m_phase = 2; m_drain_frames = 0;
        end
      end else if (m_phase == 2) begin
        m_drain_frames++;
        if (m_drain_frames == DRAIN_N) begin
          m_drain_frames = 0;
          m_shown--;
          if (m_shown == m_target) m_phase = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic check_outputs();
    chk("pixel", pixel_out, exp_pix);
    chk("flash_active", {23'd0, flash_active_out}, {23'd0, m_phase == 1});
    chk("depleted", {23'd0, depleted_out}, {23'd0, (m_target == 0 && m_shown == 0)});
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic pick_coord();
    if ($urandom_range(0, 9) < 8) begin
      hcount_in = 11'(BAR_X + (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BAR_W - 1))
                                                            : x_offs[$urandom_range(0, 19)]));
      vcount_in = 10'(y_vals[$urandom_range(0, 7)]);
    end else begin
      hcount_in = 11'($urandom_range(0, 2047));
      vcount_in = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        frame_start_in = (c == 0);
        pick_coord();
        tick();
      end
    end
    frame_start_in = 1'b0;
  endtask

  task automatic send(input int h, input bit with_fs);
    health_in = 8'(h);
    health_valid_in = 1'b1;
    frame_start_in = with_fs;
    pick_coord();
    tick();
    health_valid_in = 1'b0;
    frame_start_in = 1'b0;
  endtask

  task automatic probe(input int x, input int y);
    hcount_in = 11'(x);
    vcount_in = 10'(y);
    tick();
    pick_coord();
    tick();
    tick();
  endtask

  initial begin
    rst_in = 1'b0;
    hcount_in = '0; vcount_in = '0;
    frame_start_in = 1'b0; health_in = '0; health_valid_in = 1'b0;
    model_reset();
    #1;
    check_outputs();
    tick(); tick();
    rst_in = 1'b1;

    // full bar after reset, edge pixels
    run_frames(1);
    probe(32, 16); probe(231, 31); probe(232, 16); probe(31, 20);
    probe(231, 32); probe(232, 31);
    run_frames(1);

    // damage to 60: flash, then drain to 60
    send(60, 0);
    run_frames(95);

    // damage to 60 from full, raise to 90 mid-drain
    send(100, 0);
    run_frames(2);
    send(60, 0);
    run_frames(48);
    send(90, 0);
    run_frames(3);

    // re-damage during flash restarts it
    send(70, 0);
    run_frames(3);
    send(40, 0);
    run_frames(12);
    send(60, 1);
    run_frames(12);
    send(55, 0);
    run_frames(4);
    send(50, 1);
    run_frames(30);

    // deplete, then clamped refill
    send(0, 0);
    run_frames(120);
    send(200, 0);
    run_frames(3);

    // asynchronous reset while draining
    send(50, 0);
    run_frames(14);
    #3 rst_in = 1'b0;
    model_reset();
    #1;
    check_outputs();
    tick(); tick();
    rst_in = 1'b1;
    run_frames(2);

    // randomized health traffic
    for (int i = 0; i < 30; i++) begin
      send(int'($urandom_range(0, 130)), 1'($urandom_range(0, 1)));
      run_frames(int'($urandom_range(0, 12)));
    end
    run_frames(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
